// File: rtl/systolic_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic operand feeder:
//   - default channel count and word width
//   - feeder FSM state type
//   - lane_lsb(): bit offset of a lane inside a flattened N_CH*DATA_W bus
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEFAULT_N_CH   = 4;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } feeder_state_t;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_bank.sv
// ---------------------------------------------------------------------------
// feeder_bank
// Single-port DEPTH x DATA_W synchronous RAM with one cycle of read latency.
// Ports:
//   clk     system clock
//   i_en    access enable
//   i_we    write enable (qualified by i_en)
//   i_addr  word address
//   i_di    write data
//   o_do    registered read data; only updated by reads, so it holds its
//           value across idle cycles and writes
// The storage array and the read register are not reset.
// ---------------------------------------------------------------------------
module feeder_bank
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_di,
    output logic [DATA_W-1:0] o_do
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_do;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_di;
            end else begin
                r_do <= r_mem[i_addr];
            end
        end
    end

    assign o_do = r_do;

endmodule

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
// Streams N_CH unskewed word banks to the systolic array edge with diagonal
// skew: lane i is delayed by i beats, with the skew zeros generated here.
// Optional build macro SYSTOLIC_SKEW_FEEDER_REV_SKEW_EN: lane i is delayed by
// N_CH-1-i instead (anti-diagonal, lane N_CH-1 leads).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_en/wr_ch/      bank load port, accepted only in IDLE; wr_ch >= N_CH
//   wr_addr/wr_data   is dropped
//   start, len        stream request; len==0 ignored, len clamped to DEPTH
//   busy              high in RUN and FLUSH
//   done              one-cycle pulse on the final valid beat
//   out_valid         out_data carries a valid skewed beat
//   out_data          lane i at [i*DATA_W +: DATA_W]; holds when not valid
//
// state | meaning
// IDLE  | banks loadable, waiting for start with len != 0
// RUN   | issuing beat index t = 0 .. L+N_CH-2, one per cycle
// FLUSH | last read in flight; final beat and done are on the outputs
// ---------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N_CH   = DEFAULT_N_CH,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH + 1),
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    output logic [N_CH*DATA_W-1:0] out_data
);

`ifdef SYSTOLIC_SKEW_FEEDER_REV_SKEW_EN
    localparam bit REV_SKEW = 1'b1;
`else
    localparam bit REV_SKEW = 1'b0;
`endif

    // Beat index reaches DEPTH+N_CH-2 at most.
    localparam int T_W = $clog2(DEPTH + N_CH);

    feeder_state_t     r_state;
    feeder_state_t     w_state_nxt;
    logic [T_W-1:0]    r_t;
    logic [LEN_W-1:0]  r_len;
    logic              r_vld;
    logic [N_CH-1:0]   r_lane_vld;
    logic [N_CH-1:0]   w_rd_en;
    logic [N_CH-1:0]   w_we;
    logic              w_start_ok;
    logic              w_t_last;
    logic [LEN_W-1:0]  w_len_clamp;
    logic [DATA_W-1:0] w_do [N_CH];

    assign w_start_ok  = start && (len != '0);
    assign w_len_clamp = (int'(len) > DEPTH) ? LEN_W'(DEPTH) : len;
    assign w_t_last    = (r_t == T_W'(r_len) + T_W'(N_CH - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = RUN;
            RUN:     if (w_t_last)   w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t        <= '0;
            r_len      <= '0;
            r_vld      <= 1'b0;
            r_lane_vld <= '0;
        end else begin
            if (r_state == IDLE && w_start_ok) begin
                r_t   <= '0;
                r_len <= w_len_clamp;
            end else if (r_state == RUN) begin
                r_t <= r_t + T_W'(1);
            end
            // Beat issued in RUN lands one cycle later, alongside the bank read data.
            r_vld <= (r_state == RUN);
            if (r_state == RUN) begin
                r_lane_vld <= w_rd_en;
            end
        end
    end

    assign out_valid = r_vld;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        localparam int DLY = REV_SKEW ? (N_CH - 1 - g) : g;

        logic [T_W-1:0] w_idx;

        // w_idx wraps when t < DLY; the t >= DLY term masks that case.
        assign w_idx      = r_t - T_W'(DLY);
        assign w_rd_en[g] = (r_state == RUN) && (r_t >= T_W'(DLY)) && (w_idx < T_W'(r_len));
        assign w_we[g]    = (r_state == IDLE) && wr_en && (int'(wr_ch) == g);

        feeder_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk    (clk),
            .i_en   (w_rd_en[g] | w_we[g]),
            .i_we   (w_we[g]),
            .i_addr (w_we[g] ? wr_addr : w_idx[ADDR_W-1:0]),
            .i_di   (wr_data),
            .o_do   (w_do[g])
        );

        // Padding zeros come from the registered lane mask, not from memory.
        assign out_data[lane_lsb(g, DATA_W) +: DATA_W] = r_lane_vld[g] ? w_do[g] : '0;
    end

endmodule
